// File: rtl/rv_regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter and its users.
//   REG_AW     register address width
//   REG_DW     register data width
//   REG_ZERO   address of the hard-wired zero register
package rv_regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req  in   NUM_REQ   request vector
//   ptr  in   IW        highest-priority index this cycle
//   en   in   1         0 = grant nothing
//   gnt  out  NUM_REQ   one-hot grant, or zero when no request / disabled
//   idx  out  IW        binary index of the granted request (0 when no grant)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    int unsigned cand;
    logic        found;

    // Walk ptr, ptr+1, ... modulo NUM_REQ and take the first requester.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback sources.
// Each source presents valid/addr/data and is granted by round-robin; the winner is
// registered onto write/writeReg/writeData, which drive the regfile write port.
// Writes to x0 are accepted (ready, pointer advance) but leave write low.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   hold                  1 = grant nothing this cycle
//   req_valid/req_ready   per-source handshake (ready one-hot or zero)
//   req_addr/req_data     packed per-source address/data, source i at [i*W +: W]
//   write/writeReg/writeData  registered regfile write port
//   grant_id              index of the last accepted source
// Optional feature: define REGFILE_WB_BYPASS_EN to add two combinational forwarding
// ports (rd_addrK in, fwd_hitK/fwd_dataK out) that expose the write held in the
// output stage.
module regfile_wb_arbiter
    import rv_regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = REG_AW,
    parameter int unsigned DW      = REG_DW,
    localparam int unsigned IW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic                  write,
    output logic [AW-1:0]         writeReg,
    output logic [DW-1:0]         writeData,
    output logic [IW-1:0]         grant_id
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]         rd_addr1,
    input  logic [AW-1:0]         rd_addr2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DW-1:0]         fwd_data1,
    output logic [DW-1:0]         fwd_data2
`endif
);

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               write_q, write_d;
    logic [AW-1:0]      write_reg_q, write_reg_d;
    logic [DW-1:0]      write_data_q, write_data_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win_idx;
    logic [AW-1:0]      win_addr;
    logic [DW-1:0]      win_data;
    logic               transfer;

    // Nothing is granted while in reset so no requester believes it was accepted.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (~hold & ~rst),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    // gnt is only ever set for a valid source, so any grant bit is a transfer.
    assign transfer = |gnt;

    always_comb begin
        write_d      = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (transfer) begin
            write_d      = (win_addr != '0);
            write_reg_d  = win_addr;
            write_data_d = win_data;
            grant_id_d   = win_idx;
            rr_ptr_d     = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            write_q      <= write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign write     = write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign grant_id  = grant_id_q;

`ifdef REGFILE_WB_BYPASS_EN
    // x0 reads never forward; a zero address is always the hard-wired zero.
    assign fwd_hit1  = write_q & (write_reg_q == rd_addr1) & (rd_addr1 != '0);
    assign fwd_hit2  = write_q & (write_reg_q == rd_addr2) & (rd_addr2 != '0);
    assign fwd_data1 = write_data_q;
    assign fwd_data2 = write_data_q;
`endif

endmodule
